mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single byte-wide RAM port between instruction fetch (IF) and the data-memory stage (MEM).
- Breaks 1/2/4-byte accesses into byte-serial RAM cycles and reassembles them little-endian.
- Returns a one-cycle done pulse per request. The pipeline stalls (IF/ID, ID/EX, … buffers hold) while a requester waits for done.
- Sits between IF/MEM stage logic and the top-level RAM pins.

Parameters:
ADDR_W, 32, address width of requests and ram_addr_o
RAM_LAT, 1, cycles from ram_addr_o to valid ram_din_i (fixed at 1; other values unsupported)

Ports:
dclk  in  1  clock
rst  in  1  reset: synchronous, active-low
rdy  in  1  global ready; 0 freezes block (RAM read path is frozen by rdy at SoC level too)
if_req_i  in  1  fetch request (level, held until if_done_o)
if_addr_i  in  ADDR_W  fetch address (word fetch, 4 bytes)
if_cancel_i  in  1  branch flush: abort in-flight/pending fetch
if_data_o  out  32  fetched instruction, valid with if_done_o
if_done_o  out  1  one-cycle fetch-complete pulse
mem_req_i  in  1  data request (level, held until mem_done_o)
mem_we_i  in  1  1=store, 0=load
mem_len_i  in  2  00 byte, 01 half, 1x word
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  32  store data, LSB byte first
mem_rdata_o  out  32  load data, zero-extended, valid with mem_done_o
mem_done_o  out  1  one-cycle data-complete pulse
ram_addr_o  out  ADDR_W  RAM byte address
ram_we_o  out  1  RAM write enable
ram_dout_o  out  8  RAM write byte
ram_din_i  in  8  RAM read byte: data for ram_addr_o of previous cycle

Behaviour:
- Reset (rst=0 at dclk edge):
  - State goes to IDLE.
  - All outputs go to 0: ram_addr_o, ram_we_o, ram_dout_o, if_data_o, mem_rdata_o, if_done_o, mem_done_o.
  - Byte counter and latched request are cleared.
  - Reset mid-transfer abandons the transfer; no done pulse.
- rdy=0: every register holds. ram_we_o is driven as (registered we & rdy), so a write byte is never issued twice. Done pulses are not issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, grant:
  - Priority is fixed: MEM over IF.
  - If mem_req_i is set, latch addr/len/we/wdata, set N = 1/2/4 bytes, go to READ or WRITE.
  - Otherwise, if if_req_i && !if_cancel_i, latch if_addr_i with N=4 and go to READ.
  - Grant cycle = T. ram_addr_o is registered, so address k appears in cycle T+1+k.
- READ:
  - Issues addresses addr+0 .. addr+N-1 in cycles T+1 .. T+N.
  - Captures byte k from ram_din_i in cycle T+2+k into bits [8k+7:8k].
  - After the last capture, goes to DONE.
  - Done pulse is in cycle T+N+2 (word: T+6, byte: T+3).
- WRITE:
  - In cycles T+1 .. T+N: ram_we_o=1, ram_addr_o=addr+k, ram_dout_o=wdata[8k+7:8k].
  - Then goes to DONE; done pulse in cycle T+N+1 (word: T+5).
- DONE:
  - Exactly one of if_done_o/mem_done_o is high for exactly one cycle, with data stable.
  - ram_we_o=0. No grant is evaluated in this state.
  - Next state is IDLE. Requesters deassert or change req by the cycle after done.
- Data hold: if_data_o and mem_rdata_o hold their last value until the next completion.
- Address wrap: the address counter wraps modulo 2^ADDR_W.
- Cancel:
  - if_cancel_i=1 during an IF-owned READ → next state IDLE, ram_addr_o unchanged, no if_done_o.
  - if_cancel_i in the DONE cycle of an IF read suppresses if_done_o.
  - Cancel never affects MEM transfers.
- Simultaneous if_req_i and mem_req_i in IDLE → MEM granted. IF waits, and is served in the first IDLE cycle after mem_done_o once mem_req_i has dropped.
- A request arriving while busy is served after the current DONE; there is no preemption.

Test Plan:
1. Reset, then an IF fetch of 0x1000 with RAM bytes 13 00 00 93 at 0x1000..0x1003:
   - ram_addr_o = 0x1000..0x1003 in T+1..T+4.
   - if_done_o pulses at T+6 with if_data_o = 0x93000013.
2. MEM word store to 0x20 with wdata 0xDEADBEEF:
   - ram_we_o=1 for exactly 4 cycles, bytes EF BE AD DE to 0x20..0x23.
   - mem_done_o at T+5.
   - Follow with a byte load of 0x22 → mem_rdata_o = 0x000000AD at T+3.
3. if_req_i and mem_req_i (half load at 0x22) asserted in the same cycle:
   - MEM is served first, with mem_rdata_o = 0x0000DEAD.
   - IF grant follows in the first IDLE cycle after mem_done_o.
   - Both requesters see exactly one done pulse each.
4. if_cancel_i pulsed at T+3 of a word fetch:
   - No if_done_o.
   - FSM is IDLE at T+4; a new fetch is granted from there.
5. rdy=0 for 3 cycles in the middle of a word store:
   - No duplicated or skipped bytes; the memory image is identical to an unstalled run.
   - mem_done_o is delayed by exactly 3 cycles.
6. rst=0 asserted at T+2 of a word load:
   - All outputs are 0 the next cycle; no done pulse.
   - A fresh request after reset release completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between fetch and data stages,
// serialising 1/2/4-byte accesses little-endian with a one-cycle done pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              dclk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      state;
    logic [2:0]  ph;
    logic [2:0]  n;
    logic [1:0]  idx;
    logic        own_if;
    logic        we_r;
    logic        if_done_r;
    logic        mem_done_r;
    logic [31:0] rbuf;
    logic [31:0] wd;
    logic [31:0] cap;
    // ph counts cycles since grant; read byte k returns RAM_LAT cycles after its address
    always_comb begin
        idx = 2'(ph - 3'(RAM_LAT));
        cap = rbuf;
        cap[{idx, 3'b000} +: 8] = ram_din_i;
    end
    assign ram_we_o   = we_r & rdy;
    assign mem_done_o = mem_done_r & rdy;
    assign if_done_o  = if_done_r & rdy & ~if_cancel_i;
    always_ff @(posedge dclk) begin
        if (!rst) begin
            state       <= IDLE;
            ph          <= '0;
            n           <= '0;
            own_if      <= 1'b0;
            we_r        <= 1'b0;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
            rbuf        <= '0;
            wd          <= '0;
            ram_addr_o  <= '0;
            ram_dout_o  <= '0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
        end else if (rdy) begin
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    ph   <= '0;
                    rbuf <= '0;
                    if (mem_req_i) begin
                        ram_addr_o <= mem_addr_i;
                        own_if     <= 1'b0;
                        n          <= mem_len_i[1] ? 3'd4 : (mem_len_i[0] ? 3'd2 : 3'd1);
                        we_r       <= mem_we_i;
                        ram_dout_o <= mem_wdata_i[7:0];
                        wd         <= mem_wdata_i >> 8;
                        state      <= mem_we_i ? WRITE : READ;
                    end else if (if_req_i && !if_cancel_i) begin
                        ram_addr_o <= if_addr_i;
                        own_if     <= 1'b1;
                        n          <= 3'd4;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (own_if && if_cancel_i) begin
                        state <= IDLE;
                    end else begin
                        ph <= ph + 3'd1;
                        if (ph < n - 3'd1)
                            ram_addr_o <= ram_addr_o + ADDR_W'(1);
                        if (ph >= 3'(RAM_LAT)) begin
                            rbuf <= cap;
                            if (idx == 2'(n - 3'd1)) begin
                                state <= DONE;
                                if (own_if) begin
                                    if_data_o <= cap;
                                    if_done_r <= 1'b1;
                                end else begin
                                    mem_rdata_o <= cap;
                                    mem_done_r  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                WRITE: begin
                    ph <= ph + 3'd1;
                    if (ph == n - 3'd1) begin
                        we_r       <= 1'b0;
                        mem_done_r <= 1'b1;
                        state      <= DONE;
                    end else begin
                        ram_addr_o <= ram_addr_o + ADDR_W'(1);
                        ram_dout_o <= wd[7:0];
                        wd         <= wd >> 8;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for arbitration,
// cancel, stall and reset corners against a byte-wide RAM model.
module tb_mem_arbiter;
    logic        dclk;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        mem_init;
    logic [7:0]  ram [0:65535];
    int          wr_cnt;
    int          checks;
    int          failures;
    int          g_lat;
    int          g_oth;
    int          g_nw;
    int          g_extra;
    logic [31:0] tr_a [0:39];
    logic [31:0] pi;
    logic [31:0] pm;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        int          lat;
        int          nw;
    } vec_t;
    vec_t tbl [13];

    mem_arbiter #(.ADDR_W(32), .RAM_LAT(1)) dut (
        .dclk(dclk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_cancel_i(if_cancel),
        .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_dout_o(ram_dout),
        .ram_din_i(ram_din)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // byte RAM with one cycle read latency, frozen by rdy like the SoC
    always @(posedge dclk) begin
        if (mem_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
            ram[16'h1000] <= 8'h13;
            ram[16'h1001] <= 8'h00;
            ram[16'h1002] <= 8'h00;
            ram[16'h1003] <= 8'h93;
            wr_cnt <= 0;
        end else if (rdy) begin
            if (ram_we) begin
                ram[ram_addr[15:0]] <= ram_dout;
                wr_cnt <= wr_cnt + 1;
            end
            ram_din <= ram[ram_addr[15:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ram_addr"}, ram_addr, 32'h0);
        chk({tag, " ram_we"}, 32'(ram_we), 32'h0);
        chk({tag, " ram_dout"}, 32'(ram_dout), 32'h0);
        chk({tag, " if_data"}, if_data, 32'h0);
        chk({tag, " mem_rdata"}, mem_rdata, 32'h0);
        chk({tag, " dones"}, {30'h0, if_done, mem_done}, 32'h0);
    endtask

    task automatic xfer(input bit is_if, input bit we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall_at);
        int nw0;
        @(posedge dclk);
        #1;
        nw0 = wr_cnt;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_len   = len;
            mem_addr  = addr;
            mem_wdata = wd;
        end
        g_lat = -1;
        g_oth = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge dclk);
            tr_a[c] = ram_addr;
            if (is_if ? mem_done : if_done) g_oth++;
            if (is_if ? if_done : mem_done) begin
                g_lat = c;
                break;
            end
            if (c == stall_at) rdy = 1'b0;
            if (c == stall_at + 3) rdy = 1'b1;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        rdy     = 1'b1;
        @(negedge dclk);
        g_extra = {30'h0, if_done, mem_done};
        g_nw = wr_cnt - nw0;
    endtask

    initial begin
        int mc, ic, mt, it, dt, dn, nd;
        logic [31:0] md, idat, a4, a5;
        checks = 0;
        failures = 0;
        rst = 1'b0;
        rdy = 1'b1;
        mem_init = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        if_cancel = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_len = 2'b00;
        mem_addr = '0;
        mem_wdata = '0;
        tbl[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,         32'h9300_0013, 6, 0};
        tbl[1]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,         5, 4};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0022, 32'h0,         32'h0000_00AD, 3, 0};
        tbl[3]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0022, 32'h0,         32'h0000_DEAD, 4, 0};
        tbl[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 6, 0};
        tbl[5]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0040, 32'h1234_5678, 32'h0,         3, 2};
        tbl[6]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0040, 32'h0,         32'h0000_5678, 6, 0};
        tbl[7]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0041, 32'h0000_00AB, 32'h0,         2, 1};
        tbl[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         32'h0000_AB78, 6, 0};
        tbl[9]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 6, 0};
        tbl[10] = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'hCAFE_F00D, 32'h0,         5, 4};
        tbl[11] = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'hCAFE_F00D, 6, 0};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 32'h0000_0001, 32'h0,         32'h0000_00CA, 3, 0};

        repeat (3) @(posedge dclk);
        @(negedge dclk);
        chk_zero("reset");
        mem_init = 1'b0;
        rst = 1'b1;
        pi = '0;
        pm = '0;

        // word fetch: address sequence and latency
        xfer(1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, -1);
        for (int k = 0; k < 4; k++) chk($sformatf("fetch addr %0d", k), tr_a[k + 1], 32'h1000 + k);
        chk("fetch lat", 32'(g_lat), 32'd6);
        chk("fetch data", if_data, 32'h9300_0013);
        pi = 32'h9300_0013;

        for (int i = 0; i < 13; i++) begin
            xfer(tbl[i].is_if, tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wd, -1);
            chk($sformatf("v%0d lat", i), 32'(g_lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d writes", i), 32'(g_nw), 32'(tbl[i].nw));
            chk($sformatf("v%0d other done", i), 32'(g_oth), 32'h0);
            chk($sformatf("v%0d done width", i), 32'(g_extra), 32'h0);
            if (tbl[i].is_if) begin
                chk($sformatf("v%0d if_data", i), if_data, tbl[i].exp);
                chk($sformatf("v%0d mem hold", i), mem_rdata, pm);
                pi = tbl[i].exp;
            end else begin
                chk($sformatf("v%0d if hold", i), if_data, pi);
                if (!tbl[i].we) begin
                    chk($sformatf("v%0d mem_rdata", i), mem_rdata, tbl[i].exp);
                    pm = tbl[i].exp;
                end
            end
        end

        // simultaneous requests: MEM first, IF granted in the IDLE after mem_done
        @(posedge dclk);
        #1;
        if_req = 1'b1;
        if_addr = 32'h1000;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_len = 2'b01;
        mem_addr = 32'h22;
        mc = 0; ic = 0; mt = -1; it = -1; md = '0; idat = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge dclk);
            if (mem_done) begin
                mc++;
                mt = c;
                md = mem_rdata;
                mem_req = 1'b0;
            end
            if (if_done) begin
                ic++;
                it = c;
                idat = if_data;
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        chk("arb mem time", 32'(mt), 32'd4);
        chk("arb mem data", md, 32'h0000_DEAD);
        chk("arb if time", 32'(it), 32'd11);
        chk("arb if data", idat, 32'h9300_0013);
        chk("arb done counts", {16'(mc), 16'(ic)}, {16'd1, 16'd1});

        // cancel at T+3, then a new fetch granted from the following IDLE
        @(posedge dclk);
        #1;
        if_req = 1'b1;
        if_addr = 32'h20;
        dt = -1; dn = 0; a4 = '0; a5 = '0; idat = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge dclk);
            if (c == 4) a4 = ram_addr;
            if (c == 5) a5 = ram_addr;
            if (if_done) begin
                if (dt < 0) begin
                    dt = c;
                    idat = if_data;
                end
                dn++;
                if_req = 1'b0;
            end
            if (c == 3) begin
                if_cancel = 1'b1;
                if_addr = 32'h1000;
            end
            if (c == 4) if_cancel = 1'b0;
        end
        if_req = 1'b0;
        if_cancel = 1'b0;
        chk("cancel addr held", a4, 32'h22);
        chk("cancel regrant addr", a5, 32'h1000);
        chk("cancel done time", 32'(dt), 32'd10);
        chk("cancel done count", 32'(dn), 32'd1);
        chk("cancel new data", idat, 32'h9300_0013);

        // cancel in the DONE cycle suppresses the pulse
        @(posedge dclk);
        #1;
        if_req = 1'b1;
        if_addr = 32'h1000;
        repeat (6) @(posedge dclk);
        #1;
        if_cancel = 1'b1;
        @(negedge dclk);
        chk("done-cycle cancel", 32'(if_done), 32'h0);
        if_req = 1'b0;
        if_cancel = 1'b0;
        @(negedge dclk);
        chk("done-cycle cancel after", 32'(if_done), 32'h0);

        // three stalled cycles in the middle of a word store
        xfer(1'b0, 1'b1, 2'b10, 32'h60, 32'h1122_3344, 2);
        chk("stall lat", 32'(g_lat), 32'd8);
        chk("stall writes", 32'(g_nw), 32'd4);
        xfer(1'b0, 1'b0, 2'b10, 32'h60, 32'h0, -1);
        chk("stall readback", mem_rdata, 32'h1122_3344);
        chk("stall readback lat", 32'(g_lat), 32'd6);

        // reset at T+2 of a word load
        @(posedge dclk);
        #1;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_len = 2'b10;
        mem_addr = 32'h20;
        repeat (2) @(posedge dclk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge dclk);
        chk_zero("midreset");
        mem_req = 1'b0;
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge dclk);
            if (if_done || mem_done) nd++;
        end
        chk("midreset no done", 32'(nd), 32'h0);
        xfer(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, -1);
        chk("post reset lat", 32'(g_lat), 32'd6);
        chk("post reset data", mem_rdata, 32'hDEAD_BEEF);
        chk("post reset if clear", if_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
